// File: rtl/timer_pkg.sv
// Shared types for the round timer controller.
package timer_pkg;

  localparam int TIMER_STATE_W = 2;

  typedef enum logic [TIMER_STATE_W-1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } timer_state_e;

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: SYNC_STAGES-flop synchroniser followed by a registered
// rising-edge detector. One o_pulse per press, SYNC_STAGES+1 cycles after the
// press. A button already held when reset releases produces no pulse: edges
// are only accepted once the synchroniser has been refilled after reset.
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_vld;   // marks synchroniser stages holding post-reset samples
  logic                   r_prev;

  // Shift the button through the synchroniser and flag a 0->1 transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_vld   <= '0;
      r_prev  <= 1'b1;
      o_pulse <= 1'b0;
    end else begin
      r_sync  <= (r_sync << 1) | SYNC_STAGES'(i_btn);
      r_vld   <= (r_vld << 1) | SYNC_STAGES'(1'b1);
      r_prev  <= r_vld[SYNC_STAGES-1] ? r_sync[SYNC_STAGES-1] : 1'b1;
      o_pulse <= r_vld[SYNC_STAGES-1] & r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Round controller for the seconds timer: start/pause/resume/stop sequencing,
// time-left, warning window and time-up pulse.
// Optional build macro TIMER_CTRL_BTN_EN: request inputs are raw button levels
// conditioned by btn_edge; otherwise they are synchronous one-cycle pulses.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TIMER_WIDTH = 16,
  parameter int WARN_SECS   = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic                     i_pause_req,
  input  logic                     i_stop,
  input  logic [TIMER_WIDTH-1:0]   i_time_limit,
  input  logic [TIMER_WIDTH-1:0]   i_current_time,
  output logic                     o_pause,
  output logic                     o_reset_timer,
  output logic [TIMER_STATE_W-1:0] o_state,
  output logic [TIMER_WIDTH-1:0]   o_time_left,
  output logic                     o_warning,
  output logic                     o_time_up
);

  localparam logic [TIMER_WIDTH-1:0] LP_WARN = TIMER_WIDTH'(WARN_SECS);

  if (SYNC_STAGES < 1) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 1");
  end

  logic w_start, w_pause, w_stop;

`ifdef TIMER_CTRL_BTN_EN
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn_start (
    .clk(clk), .rst_n(rst_n), .i_btn(i_start), .o_pulse(w_start));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn_pause (
    .clk(clk), .rst_n(rst_n), .i_btn(i_pause_req), .o_pulse(w_pause));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn_stop (
    .clk(clk), .rst_n(rst_n), .i_btn(i_stop), .o_pulse(w_stop));
`else
  assign w_start = i_start;
  assign w_pause = i_pause_req;
  assign w_stop  = i_stop;
`endif

  timer_state_e             r_state;
  logic                     r_expired;
  logic [TIMER_WIDTH-1:0]   r_limit;

  timer_state_e             w_nxt_state;
  logic                     w_nxt_expired;
  logic [TIMER_WIDTH-1:0]   w_nxt_limit;
  logic                     w_expire;
  logic                     w_hit;
  logic                     w_active;
  logic [TIMER_WIDTH-1:0]   w_left;
  logic                     w_warn;

  // Next state with priority stop > start > expiry > pause, plus the values
  // the registered outputs will take after this edge.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_expired = r_expired;
    w_nxt_limit   = r_limit;
    w_expire      = 1'b0;
    w_hit         = (r_limit != '0) && (i_current_time >= r_limit);
    if (w_stop) begin
      w_nxt_state = IDLE;
    end else if (w_start) begin
      w_nxt_state = ARM;
      w_nxt_limit = i_time_limit;
    end else begin
      case (r_state)
        ARM:   w_nxt_state = RUN;
        RUN: begin
          if (w_hit) begin
            w_nxt_state   = PAUSE;
            w_nxt_expired = 1'b1;
            w_expire      = 1'b1;
          end else if (w_pause) begin
            w_nxt_state = PAUSE;
          end
        end
        PAUSE: if (w_pause && !r_expired) w_nxt_state = RUN;
        default: w_nxt_state = r_state;
      endcase
    end
    // The expired flag only has meaning while parked in PAUSE.
    if (w_nxt_state == IDLE || w_nxt_state == ARM) w_nxt_expired = 1'b0;

    w_active = (w_nxt_state == RUN) || (w_nxt_state == PAUSE);
    w_left   = (w_active && (w_nxt_limit > i_current_time)) ?
               (w_nxt_limit - i_current_time) : '0;
    w_warn   = w_active && (w_nxt_limit != '0) && (w_left != '0) && (w_left <= LP_WARN);
  end

  // State, latched limit and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_expired     <= 1'b0;
      r_limit       <= '0;
      o_pause       <= 1'b1;
      o_reset_timer <= 1'b0;
      o_time_left   <= '0;
      o_warning     <= 1'b0;
      o_time_up     <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_expired     <= w_nxt_expired;
      r_limit       <= w_nxt_limit;
      o_pause       <= (w_nxt_state != RUN);
      o_reset_timer <= (w_nxt_state == ARM);
      o_time_left   <= w_left;
      o_warning     <= w_warn;
      o_time_up     <= w_expire;
    end
  end

  assign o_state = r_state;

endmodule
